// File: rtl/multi_sram_port_arb.sv
// Round-robin arbiter that shares one SRAM port among NREQ requesters and routes read data back by tag.
// Optional stall statistics counter enabled by defining MULTI_SRAM_ARB_STATS_EN.
module multi_sram_port_arb #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 32,
  parameter int NRAMWIDHT = 5,
  parameter int AWIDTH    = 13,
  parameter int RD_LAT    = 1,
  localparam int AW = NRAMWIDHT + AWIDTH,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NREQ-1:0]        req_in,
  input  logic [NREQ-1:0]        we_in,
  input  logic [NREQ*AW-1:0]     addr_in,
  input  logic [NREQ*DWIDTH-1:0] d_in,
  output logic [NREQ-1:0]        gnt_out,
  output logic [NREQ-1:0]        rvalid_out,
  output logic [DWIDTH-1:0]      d_out,
  output logic                   en_out,
  output logic                   we_out,
  output logic [AW-1:0]          addr_out,
  output logic [DWIDTH-1:0]      d_sram_out,
  input  logic [DWIDTH-1:0]      d_sram_in
`ifdef MULTI_SRAM_ARB_STATS_EN
  ,
  output logic [15:0]            stall_cnt_out
`endif
);

  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_nxt;
  logic [PW-1:0]     gnt_idx;
  logic              xfer;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DWIDTH-1:0] sel_d;
  logic [RD_LAT-1:0] tag_v;
  logic [PW-1:0]     tag_idx [RD_LAT];
  logic [NREQ-1:0]   rvalid_nxt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    int j;
    int nx;
    gnt_out = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!xfer && req_in[j]) begin
        xfer    = 1'b1;
        gnt_idx = j[PW-1:0];
      end
    end
    // Nothing may transfer while reset is asserted.
    if (rst_in) xfer = 1'b0;
    if (xfer) gnt_out[gnt_idx] = 1'b1;
    nx = int'(gnt_idx) + 1;
    if (nx >= NREQ) nx = 0;
    ptr_nxt = nx[PW-1:0];
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_d    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_out[i]) begin
        sel_we   = we_in[i];
        sel_addr = addr_in[i*AW +: AW];
        sel_d    = d_in[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    rvalid_nxt = '0;
    rvalid_nxt[tag_idx[RD_LAT-1]] = tag_v[RD_LAT-1];
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr        <= '0;
      en_out     <= 1'b0;
      we_out     <= 1'b0;
      addr_out   <= '0;
      d_sram_out <= '0;
      tag_v      <= '0;
      rvalid_out <= '0;
      d_out      <= '0;
    end else begin
      en_out <= xfer;
      we_out <= xfer & sel_we;
      if (xfer) begin
        ptr        <= ptr_nxt;
        addr_out   <= sel_addr;
        d_sram_out <= sel_d;
      end
      tag_v[0] <= xfer & ~sel_we;
      for (int s = 1; s < RD_LAT; s++) tag_v[s] <= tag_v[s-1];
      rvalid_out <= rvalid_nxt;
      if (tag_v[RD_LAT-1]) d_out <= d_sram_in;
    end
  end

  // NOTE: tag indices are only consumed when the matching tag_v bit is set, so they need no reset.
  always_ff @(posedge clk_in) begin
    tag_idx[0] <= gnt_idx;
    for (int s = 1; s < RD_LAT; s++) tag_idx[s] <= tag_idx[s-1];
  end

`ifdef MULTI_SRAM_ARB_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
    end else if (((req_in & ~gnt_out) != '0) && (stall_cnt_out != 16'hFFFF)) begin
      stall_cnt_out <= stall_cnt_out + 16'd1;
    end
  end
`else
  // Stall statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_multi_sram_port_arb.sv
// Directed bench for multi_sram_port_arb: table of per-cycle vectors plus reset / mid-read reset sequences.
// Stall counter checks are compiled when MULTI_SRAM_ARB_STATS_EN is defined.
module tb_multi_sram_port_arb;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int AW   = 18;

  logic              clk_in;
  logic              rst_in;
  logic [NREQ-1:0]   req_in;
  logic [NREQ-1:0]   we_in;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ*DW-1:0] d_in;
  logic [NREQ-1:0]   gnt_out;
  logic [NREQ-1:0]   rvalid_out;
  logic [DW-1:0]     d_out;
  logic              en_out;
  logic              we_out;
  logic [AW-1:0]     addr_out;
  logic [DW-1:0]     d_sram_out;
  logic [DW-1:0]     d_sram_in;
`ifdef MULTI_SRAM_ARB_STATS_EN
  logic [15:0]       stall_cnt_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  multi_sram_port_arb #(
    .NREQ(NREQ), .DWIDTH(DW), .NRAMWIDHT(5), .AWIDTH(13), .RD_LAT(1)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .we_in(we_in),
    .addr_in(addr_in), .d_in(d_in), .gnt_out(gnt_out), .rvalid_out(rvalid_out),
    .d_out(d_out), .en_out(en_out), .we_out(we_out), .addr_out(addr_out),
    .d_sram_out(d_sram_out), .d_sram_in(d_sram_in)
`ifdef MULTI_SRAM_ARB_STATS_EN
    , .stall_cnt_out(stall_cnt_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // SRAM model: read data for address A is 32'hCAFE0000 + (A - 18'h01232), sampled RD_LAT edges after en_out.
  assign d_sram_in = 32'hCAFE_0000 + {14'b0, addr_out - 18'h01232};

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [3:0]  gnt;
    logic        en;
    logic        wo;
    logic [17:0] addr;
    logic [31:0] dsram;
    logic [3:0]  rv;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Requester i: addr 18'h01232+i, data 32'hDEADBEED+i.
    for (int i = 0; i < NREQ; i++) begin
      addr_in[i*AW +: AW] = 18'h01232 + 18'(i);
      d_in[i*DW +: DW]    = 32'hDEAD_BEED + 32'(i);
    end

    //            req    we     gnt    en    wo    addr       dsram          rv     dout
    vecs[0]  = '{4'hF, 4'hF, 4'h1, 1'b0, 1'b0, 18'h00000, 32'h0000_0000, 4'h0, 32'h0};
    vecs[1]  = '{4'hF, 4'hF, 4'h2, 1'b1, 1'b1, 18'h01232, 32'hDEAD_BEED, 4'h0, 32'h0};
    vecs[2]  = '{4'hF, 4'hF, 4'h4, 1'b1, 1'b1, 18'h01233, 32'hDEAD_BEEE, 4'h0, 32'h0};
    vecs[3]  = '{4'hF, 4'hF, 4'h8, 1'b1, 1'b1, 18'h01234, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vecs[4]  = '{4'hF, 4'hF, 4'h1, 1'b1, 1'b1, 18'h01235, 32'hDEAD_BEF0, 4'h0, 32'h0};
    vecs[5]  = '{4'hF, 4'hF, 4'h2, 1'b1, 1'b1, 18'h01232, 32'hDEAD_BEED, 4'h0, 32'h0};
    vecs[6]  = '{4'hF, 4'hF, 4'h4, 1'b1, 1'b1, 18'h01233, 32'hDEAD_BEEE, 4'h0, 32'h0};
    vecs[7]  = '{4'hF, 4'hF, 4'h8, 1'b1, 1'b1, 18'h01234, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vecs[8]  = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 18'h01235, 32'hDEAD_BEF0, 4'h0, 32'h0};
    vecs[9]  = '{4'h2, 4'h0, 4'h2, 1'b0, 1'b0, 18'h01235, 32'hDEAD_BEF0, 4'h0, 32'h0};
    vecs[10] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 18'h01233, 32'hDEAD_BEEE, 4'h0, 32'h0};
    vecs[11] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 18'h01233, 32'hDEAD_BEEE, 4'h2, 32'hCAFE_0001};
    vecs[12] = '{4'h4, 4'h4, 4'h4, 1'b0, 1'b0, 18'h01233, 32'hDEAD_BEEE, 4'h0, 32'hCAFE_0001};
    vecs[13] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 18'h01234, 32'hDEAD_BEEF, 4'h0, 32'hCAFE_0001};
    vecs[14] = '{4'h5, 4'h0, 4'h1, 1'b0, 1'b0, 18'h01234, 32'hDEAD_BEEF, 4'h0, 32'hCAFE_0001};
    vecs[15] = '{4'h5, 4'h0, 4'h4, 1'b1, 1'b0, 18'h01232, 32'hDEAD_BEED, 4'h0, 32'hCAFE_0001};
    vecs[16] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 18'h01234, 32'hDEAD_BEEF, 4'h1, 32'hCAFE_0000};
    vecs[17] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 18'h01234, 32'hDEAD_BEEF, 4'h4, 32'hCAFE_0002};
    vecs[18] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 18'h01234, 32'hDEAD_BEEF, 4'h0, 32'hCAFE_0002};

    // Reset held with every requester asserting: no grant, all registered outputs zero.
    rst_in = 1'b1;
    req_in = 4'hF;
    we_in  = 4'hF;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      check($sformatf("rst%0d gnt", c), 64'(gnt_out), 64'h0);
      check($sformatf("rst%0d en/we/rvalid", c), 64'({en_out, we_out, rvalid_out}), 64'h0);
      check($sformatf("rst%0d addr", c), 64'(addr_out), 64'h0);
      check($sformatf("rst%0d dsram/dout", c), {d_sram_out, d_out}, 64'h0);
`ifdef MULTI_SRAM_ARB_STATS_EN
      check($sformatf("rst%0d stall", c), 64'(stall_cnt_out), 64'h0);
`endif
      next_cycle();
    end
    rst_in = 1'b0;

    // Per-cycle vectors: fairness, write, read return, wrap/skip.
    for (int v = 0; v < 19; v++) begin
      req_in = vecs[v].req;
      we_in  = vecs[v].we;
      @(negedge clk_in);
      check($sformatf("v%0d gnt", v), 64'(gnt_out), 64'(vecs[v].gnt));
      check($sformatf("v%0d en", v), 64'(en_out), 64'(vecs[v].en));
      check($sformatf("v%0d we_out", v), 64'(we_out), 64'(vecs[v].wo));
      check($sformatf("v%0d addr", v), 64'(addr_out), 64'(vecs[v].addr));
      check($sformatf("v%0d dsram", v), 64'(d_sram_out), 64'(vecs[v].dsram));
      check($sformatf("v%0d rvalid", v), 64'(rvalid_out), 64'(vecs[v].rv));
      check($sformatf("v%0d dout", v), 64'(d_out), 64'(vecs[v].dout));
      next_cycle();
    end

    // Three back-to-back reads (pointer is at 3), then a one-cycle reset pulse.
    req_in = 4'b0111;
    we_in  = 4'b0000;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk_in);
      check($sformatf("rd%0d gnt", r), 64'(gnt_out), 64'(4'b0001 << r));
      next_cycle();
    end
    req_in = 4'b0000;
    rst_in = 1'b1;
    @(negedge clk_in);
    check("midrst gnt", 64'(gnt_out), 64'h0);
    next_cycle();
    rst_in = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      check($sformatf("postrst%0d rvalid", c), 64'(rvalid_out), 64'h0);
      next_cycle();
    end

    // Two requesters contending for 10 cycles: one is always waiting.
    req_in = 4'b0011;
    we_in  = 4'b0011;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      check($sformatf("cont%0d gnt", c), 64'(gnt_out), (c % 2 == 0) ? 64'h1 : 64'h2);
      next_cycle();
    end
    req_in = 4'b0000;
    @(negedge clk_in);
`ifdef MULTI_SRAM_ARB_STATS_EN
    check("stall count", 64'(stall_cnt_out), 64'd10);
`endif
    check("idle gnt", 64'(gnt_out), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
